// File: rtl/answer_bcd_conv_pkg.sv
// calc_pkg: constants and types shared by the calculator datapath.
//   CALC_WIDTH   - answer width, two's complement (matches Arth_module)
//   CALC_DIGITS  - number of BCD digits shown on the display
//   calc_state_e - converter FSM states (ST_IDLE, ST_SHIFT, ST_DONE), binary encoded
//   calc_op_e    - opcode encoding shared with Arth_module
package calc_pkg;

  localparam int CALC_WIDTH  = 17;
  localparam int CALC_DIGITS = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } calc_state_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } calc_op_e;

endpackage

// File: rtl/answer_bcd_conv_if.sv
// answer_bcd_conv_if: bundle between Arth_module's result and the display path.
//   answer (WIDTH)    two's-complement result
//   ovw               overflow flag from the arithmetic unit
//   sign              1 = displayed result is negative
//   bcd (4*DIGITS)    digit i at bcd[4i+3:4i], digit 0 = units
//   err               overflow flag belonging to the displayed result
//   valid             sign/bcd/err/blank hold a finished conversion
//   blank (DIGITS)    leading-zero mask, 1 = digit dark
// Modports: master = result producer / display consumer side, slave = converter.
interface answer_bcd_conv_if
  import calc_pkg::*;
#(
  parameter int WIDTH  = CALC_WIDTH,
  parameter int DIGITS = CALC_DIGITS
) ();

  logic [WIDTH-1:0]    answer;
  logic                ovw;
  logic                sign;
  logic [4*DIGITS-1:0] bcd;
  logic                err;
  logic                valid;
  logic [DIGITS-1:0]   blank;

  modport master (
    output answer, ovw,
    input  sign, bcd, err, valid, blank
  );

  modport slave (
    input  answer, ovw,
    output sign, bcd, err, valid, blank
  );

endinterface

// File: rtl/answer_bcd_conv_bcd_digit_adj.sv
// bcd_digit_adj: double-dabble correction for one BCD digit.
//   din  (4) digit before the shift
//   dout (4) din >= 5 ? din + 3 : din
module bcd_digit_adj (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/answer_bcd_conv.sv
// answer_bcd_conv: converts the signed arithmetic result into sign + BCD digits
// with an iterative double-dabble, one bit per clock. A conversion starts on its
// own whenever answer/ovw differ from the last converted pair (or after reset).
// Ports:
//   clock  rising-edge system clock
//   reset  asynchronous, active-high
//   bus    answer_bcd_conv_if.slave: answer/ovw in; sign/bcd/err/valid/blank out
// Optional feature macro: LEAD_ZERO_BLANK_EN (leading-zero blanking mask on bus.blank;
// when undefined bus.blank is tied to zero).
module answer_bcd_conv
  import calc_pkg::*;
#(
  parameter int WIDTH  = CALC_WIDTH,
  parameter int DIGITS = CALC_DIGITS
) (
  input logic              clock,
  input logic              reset,
  answer_bcd_conv_if.slave bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + WIDTH;
  localparam int CNT_W = $clog2(WIDTH + 1);

  calc_state_e       state_reg, state_next;
  logic [SR_W-1:0]   shift_reg, shift_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [WIDTH-1:0]  last_ans_reg, last_ans_next;
  logic              last_ovw_reg, last_ovw_next;
  logic              force_conv_reg, force_conv_next;
  logic              sign_reg, sign_next;
  logic [BCD_W-1:0]  bcd_reg, bcd_next;
  logic              err_reg, err_next;
  logic              valid_reg, valid_next;
  logic [BCD_W-1:0]  adj_bcd;
  logic [WIDTH-1:0]  mag;
  logic              start;

  // Per-digit add-3 correction applied to the BCD field before each shift.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      bcd_digit_adj u_adj (
        .din  (shift_reg[WIDTH + 4*gi +: 4]),
        .dout (adj_bcd[4*gi +: 4])
      );
    end
  endgenerate

  // Magnitude as WIDTH-bit unsigned: the most negative value maps to 2**(WIDTH-1).
  assign mag   = bus.answer[WIDTH-1] ? (~bus.answer + WIDTH'(1)) : bus.answer;
  assign start = force_conv_reg | (bus.answer != last_ans_reg) | (bus.ovw != last_ovw_reg);

`ifdef LEAD_ZERO_BLANK_EN
  logic [DIGITS-1:0] blank_reg, blank_next;
  logic [DIGITS-1:0] lead_zero;

  // lead_zero[i]: digit i and every digit above it are zero. Units never blank.
  assign lead_zero[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < DIGITS; gi++) begin : g_blank
      if (gi == DIGITS - 1) begin : g_top
        assign lead_zero[gi] = (shift_reg[WIDTH + 4*gi +: 4] == 4'd0);
      end else begin : g_mid
        assign lead_zero[gi] = (shift_reg[WIDTH + 4*gi +: 4] == 4'd0) && lead_zero[gi+1];
      end
    end
  endgenerate
`endif

  always_comb begin
    state_next      = state_reg;
    shift_next      = shift_reg;
    cnt_next        = cnt_reg;
    last_ans_next   = last_ans_reg;
    last_ovw_next   = last_ovw_reg;
    force_conv_next = force_conv_reg;
    sign_next       = sign_reg;
    bcd_next        = bcd_reg;
    err_next        = err_reg;
    valid_next      = valid_reg;
`ifdef LEAD_ZERO_BLANK_EN
    blank_next      = blank_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          last_ans_next   = bus.answer;
          last_ovw_next   = bus.ovw;
          shift_next      = {{BCD_W{1'b0}}, mag};
          cnt_next        = CNT_W'(WIDTH);
          force_conv_next = 1'b0;
          valid_next      = 1'b0;
          state_next      = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // Outgoing MSB of the adjusted field is always zero for in-range inputs.
        shift_next = {adj_bcd, shift_reg[WIDTH-1:0]} << 1;
        cnt_next   = cnt_reg - CNT_W'(1);
        if (cnt_reg == CNT_W'(1)) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        sign_next  = last_ans_reg[WIDTH-1];
        bcd_next   = shift_reg[SR_W-1 -: BCD_W];
        err_next   = last_ovw_reg;
        valid_next = 1'b1;
`ifdef LEAD_ZERO_BLANK_EN
        blank_next = lead_zero;
`endif
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      shift_reg      <= '0;
      cnt_reg        <= '0;
      last_ans_reg   <= '0;
      last_ovw_reg   <= 1'b0;
      force_conv_reg <= 1'b1;
      sign_reg       <= 1'b0;
      bcd_reg        <= '0;
      err_reg        <= 1'b0;
      valid_reg      <= 1'b0;
`ifdef LEAD_ZERO_BLANK_EN
      blank_reg      <= '0;
`endif
    end else begin
      state_reg      <= state_next;
      shift_reg      <= shift_next;
      cnt_reg        <= cnt_next;
      last_ans_reg   <= last_ans_next;
      last_ovw_reg   <= last_ovw_next;
      force_conv_reg <= force_conv_next;
      sign_reg       <= sign_next;
      bcd_reg        <= bcd_next;
      err_reg        <= err_next;
      valid_reg      <= valid_next;
`ifdef LEAD_ZERO_BLANK_EN
      blank_reg      <= blank_next;
`endif
    end
  end

  assign bus.sign  = sign_reg;
  assign bus.bcd   = bcd_reg;
  assign bus.err   = err_reg;
  assign bus.valid = valid_reg;
`ifdef LEAD_ZERO_BLANK_EN
  assign bus.blank = blank_reg;
`else
  assign bus.blank = '0;
`endif

endmodule

// File: tb/tb_answer_bcd_conv.sv
// tb_answer_bcd_conv: directed vectors with hand-computed BCD results. Stimulus
// pushes the expected result into a scoreboard queue; a monitor pops and compares
// each time valid rises. Stimulus also checks latency and output hold timing.
module tb_answer_bcd_conv;
  import calc_pkg::*;

  typedef struct {
    logic        sign;
    logic [19:0] bcd;
    logic        err;
    logic [4:0]  blank;
    string       name;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  answer_bcd_conv_if bus_if ();

  answer_bcd_conv dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          done_count = 0;
  logic [19:0] shown_bcd = 20'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [4:0] blank_req(input logic [4:0] b);
`ifdef LEAD_ZERO_BLANK_EN
    return b;
`else
    return (b & 5'b0);
`endif
  endfunction

  function automatic exp_t mk(input logic s, input logic [19:0] b, input logic e,
                              input logic [4:0] bl, input string n);
    exp_t x;
    x.sign = s; x.bcd = b; x.err = e; x.blank = bl; x.name = n;
    return x;
  endfunction

  // Monitor: one comparison set per finished conversion.
  initial begin
    logic prev_valid;
    exp_t e;
    prev_valid = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_valid = 1'b0;
      end else begin
        if (bus_if.valid && !prev_valid) begin
          if (sb.size() == 0) begin
            check("unexpected_result", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            $display("result %s: sign=%0b bcd=%05h err=%0b blank=%05b",
                     e.name, bus_if.sign, bus_if.bcd, bus_if.err, bus_if.blank);
            check({e.name, "_sign"},  {31'd0, bus_if.sign}, {31'd0, e.sign});
            check({e.name, "_bcd"},   {12'd0, bus_if.bcd},  {12'd0, e.bcd});
            check({e.name, "_err"},   {31'd0, bus_if.err},  {31'd0, e.err});
            check({e.name, "_blank"}, {27'd0, bus_if.blank}, {27'd0, blank_req(e.blank)});
          end
          done_count++;
        end
        prev_valid = bus_if.valid;
      end
    end
  end

  // One full conversion: valid must stay low E0..E17 and rise after E18.
  task automatic convert(input logic [16:0] a, input logic o, input logic s,
                         input logic [19:0] b, input logic [4:0] bl,
                         input string name, input bit release_rst);
    int high_cnt;
    @(negedge clock);
    bus_if.answer = a;
    bus_if.ovw    = o;
    if (release_rst) reset = 1'b0;
    sb.push_back(mk(s, b, o, bl, name));
    high_cnt = 0;
    for (int k = 0; k < 18; k++) begin
      @(posedge clock);
      #1;
      if (bus_if.valid) high_cnt++;
      if (k == 9) check({name, "_old_bcd_held"}, {12'd0, bus_if.bcd}, {12'd0, shown_bcd});
    end
    check({name, "_valid_low_E0_E17"}, high_cnt, 32'd0);
    @(posedge clock);
    #1;
    check({name, "_valid_after_E18"}, {31'd0, bus_if.valid}, 32'd1);
    shown_bcd = b;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int high_cnt;
    bus_if.answer = 17'd0;
    bus_if.ovw    = 1'b0;
    reset         = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("reset_valid", {31'd0, bus_if.valid}, 32'd0);
    check("reset_sign",  {31'd0, bus_if.sign},  32'd0);
    check("reset_bcd",   {12'd0, bus_if.bcd},   32'd0);
    check("reset_err",   {31'd0, bus_if.err},   32'd0);
    check("reset_blank", {27'd0, bus_if.blank}, 32'd0);

    convert(17'd0,       1'b0, 1'b0, 20'h00000, 5'b11110, "zero",   1'b1);
    convert(17'd15,      1'b0, 1'b0, 20'h00015, 5'b11100, "p15",    1'b0);
    convert(17'h1FFA6,   1'b0, 1'b1, 20'h00090, 5'b11100, "m90",    1'b0);
    convert(17'h10000,   1'b0, 1'b1, 20'h65536, 5'b00000, "m65536", 1'b0);

    // Input change during SHIFT: 14 finishes first, then 200 nineteen clocks later.
    @(negedge clock);
    bus_if.answer = 17'd14;
    sb.push_back(mk(1'b0, 20'h00014, 1'b0, 5'b11100, "p14"));
    repeat (5) @(posedge clock);
    @(negedge clock);
    bus_if.answer = 17'd200;
    sb.push_back(mk(1'b0, 20'h00200, 1'b0, 5'b11000, "p200"));
    repeat (13) @(posedge clock);
    @(posedge clock);
    #1;
    check("p14_valid_after_E18", {31'd0, bus_if.valid}, 32'd1);
    high_cnt = 0;
    for (int k = 0; k < 18; k++) begin
      @(posedge clock);
      #1;
      if (bus_if.valid) high_cnt++;
    end
    check("p200_valid_low", high_cnt, 32'd0);
    @(posedge clock);
    #1;
    check("p200_valid_19_later", {31'd0, bus_if.valid}, 32'd1);
    shown_bcd = 20'h00200;

    convert(17'h0FFFF, 1'b1, 1'b0, 20'h65535, 5'b00000, "ovf",      1'b0);
    convert(17'h0FFFF, 1'b0, 1'b0, 20'h65535, 5'b00000, "ovw_drop", 1'b0);

    // Reset in the middle of a conversion clears outputs immediately.
    @(negedge clock);
    bus_if.answer = 17'd77;
    repeat (9) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_valid", {31'd0, bus_if.valid}, 32'd0);
    check("midrst_bcd",   {12'd0, bus_if.bcd},   32'd0);
    check("midrst_sign",  {31'd0, bus_if.sign},  32'd0);
    check("midrst_err",   {31'd0, bus_if.err},   32'd0);
    shown_bcd = 20'h0;

    convert(17'd90, 1'b0, 1'b0, 20'h00090, 5'b11100, "p90_after_rst", 1'b1);

    @(negedge clock);
    #1;
    check("results_seen", done_count, 32'd9);
    check("scoreboard_empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
